// File: rtl/lc3_fetch_unit.sv
// LC-3 fetch stage: PC/IR registers, instruction fetch over req/ack,
// HALT on TRAP x25 or bus timeout, retired-instruction counter.
module lc3_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        resume,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ip,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic [15:0] next_ip,
    output logic        halted,
    output logic        bus_err,
    output logic [15:0] instr_count
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);
    localparam logic [15:0] TRAP_HALT = 16'hF025;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE,
        HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   pc;
    logic [15:0]   pc_nxt;
    logic [15:0]   ir_nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_nxt;
    logic          bus_err_nxt;
    logic          retire;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        wait_nxt    = wait_cnt;
        bus_err_nxt = bus_err;
        retire      = 1'b0;
        unique case (state)
            IDLE: begin
                if (run)
                    state_nxt = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_nxt    = mem_rdata;
                    wait_nxt  = '0;
                    state_nxt = DECODE;
                end else if (wait_cnt == WAIT_MAX) begin
                    wait_nxt    = '0;
                    bus_err_nxt = 1'b1;
                    state_nxt   = HALT;
                end else begin
                    wait_nxt = wait_cnt + CW'(1);
                end
            end
            DECODE: begin
                if (exec_done) begin
                    retire = 1'b1;
                    if (ir == TRAP_HALT) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = next_ip;
                        state_nxt = run ? FETCH : IDLE;
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    state_nxt = FETCH;
                    // a timeout halt retries the same word; a TRAP halt skips it
                    if (bus_err)
                        bus_err_nxt = 1'b0;
                    else
                        pc_nxt = pc + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            mem_req  <= 1'b0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            wait_cnt <= wait_nxt;
            bus_err  <= bus_err_nxt;
            mem_req  <= (state_nxt == FETCH);
            ir_valid <= (state_nxt == DECODE);
            halted   <= (state_nxt == HALT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_count <= '0;
        else if (retire)
            instr_count <= instr_count + 16'd1;
    end

    assign ip       = pc;
    assign mem_addr = pc;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Scoreboard bench for lc3_fetch_unit: fetch addresses and IR words are
// queued by stimulus and checked by a monitor on each req / ir_valid rise.
module tb_lc3_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        resume;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] ip;
    logic [15:0] ir;
    logic        ir_valid;
    logic        exec_done;
    logic [15:0] next_ip;
    logic        halted;
    logic        bus_err;
    logic [15:0] instr_count;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_addr[$];
    logic [15:0] exp_ir[$];

    always #5 clk = ~clk;

    lc3_fetch_unit #(
        .RESET_PC(16'h3000),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .resume     (resume),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ip         (ip),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .exec_done  (exec_done),
        .next_ip    (next_ip),
        .halted     (halted),
        .bus_err    (bus_err),
        .instr_count(instr_count)
    );

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // monitor: every new request and every new valid IR is scored
    initial begin
        logic req_q;
        logic val_q;
        req_q = 1'b0;
        val_q = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !req_q) begin
                if (exp_addr.size() == 0)
                    check("unexpected_req", mem_addr, 16'hxxxx);
                else
                    check("fetch_addr", mem_addr, exp_addr.pop_front());
            end
            if (ir_valid && !val_q) begin
                if (exp_ir.size() == 0)
                    check("unexpected_ir", ir, 16'hxxxx);
                else
                    check("ir_word", ir, exp_ir.pop_front());
            end
            req_q = mem_req;
            val_q = ir_valid;
        end
    end

    task automatic fetch(input logic [15:0] data, input int delay);
        int n;
        n = 0;
        exp_ir.push_back(data);
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req) begin
            check("req_timeout", {15'd0, mem_req}, 16'd1);
            return;
        end
        repeat (delay - 1) tick();
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    task automatic exec(input logic [15:0] nip);
        exec_done = 1'b1;
        next_ip   = nip;
        tick();
        exec_done = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        resume    = 1'b0;
        mem_rdata = 16'h0000;
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        next_ip   = 16'h0000;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_ip", ip, 16'h3000);
        check("rst_ir", ir, 16'h0000);
        check("rst_req", {15'd0, mem_req}, 16'd0);
        check("rst_valid", {15'd0, ir_valid}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_buserr", {15'd0, bus_err}, 16'd0);
        check("rst_count", instr_count, 16'd0);

        // 1: single-cycle fetch
        exp_addr.push_back(16'h3000);
        run = 1'b1;
        fetch(16'h1021, 1);
        check("valid_after_ack", {15'd0, ir_valid}, 16'd1);

        // 2: retire, jump to 3005
        exp_addr.push_back(16'h3005);
        exec(16'h3005);
        check("valid_drop", {15'd0, ir_valid}, 16'd0);
        check("count_1", instr_count, 16'd1);
        fetch(16'h5020, 2);

        // 3: bus timeout at 3000
        exp_addr.push_back(16'h3000);
        exec(16'h3000);
        repeat (15) tick();
        check("halt_early", {15'd0, halted}, 16'd0);
        tick();
        check("to_halted", {15'd0, halted}, 16'd1);
        check("to_buserr", {15'd0, bus_err}, 16'd1);
        check("to_ip", ip, 16'h3000);
        check("to_req", {15'd0, mem_req}, 16'd0);
        check("to_count", instr_count, 16'd2);
        exp_addr.push_back(16'h3000);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("res_buserr", {15'd0, bus_err}, 16'd0);
        check("res_halted", {15'd0, halted}, 16'd0);
        fetch(16'h1021, 1);

        // 4: TRAP x25 at 3002
        exp_addr.push_back(16'h3002);
        exec(16'h3002);
        fetch(16'hF025, 2);
        exec(16'h1234);
        check("trap_halted", {15'd0, halted}, 16'd1);
        check("trap_count", instr_count, 16'd4);
        check("trap_ip", ip, 16'h3002);
        check("trap_valid", {15'd0, ir_valid}, 16'd0);
        check("trap_buserr", {15'd0, bus_err}, 16'd0);
        exp_addr.push_back(16'h3003);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("trap_res_ip", ip, 16'h3003);

        // 5: run drops mid-fetch; exec_done with resume goes idle
        run = 1'b0;
        fetch(16'h1262, 3);
        resume = 1'b1;
        exec(16'h3010);
        resume = 1'b0;
        check("idle_ip", ip, 16'h3010);
        check("idle_halted", {15'd0, halted}, 16'd0);
        check("idle_count", instr_count, 16'd5);
        repeat (4) tick();
        check("idle_req", {15'd0, mem_req}, 16'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack   = 1'b0;
        check("stray_ack_ir", ir, 16'h1262);
        check("stray_ack_valid", {15'd0, ir_valid}, 16'd0);

        // 6: reset mid-fetch, late ack ignored
        exp_addr.push_back(16'h3010);
        run = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("arst_req", {15'd0, mem_req}, 16'd0);
        check("arst_ip", ip, 16'h3000);
        tick();
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack   = 1'b0;
        check("late_ack_ir", ir, 16'h0000);
        check("late_ack_ip", ip, 16'h3000);
        check("late_ack_req", {15'd0, mem_req}, 16'd0);
        check("late_ack_count", instr_count, 16'd0);

        // counter wrap on retire
        force dut.instr_count = 16'hFFFF;
        tick();
        release dut.instr_count;
        tick();
        check("wrap_pre", instr_count, 16'hFFFF);
        exp_addr.push_back(16'h3000);
        run = 1'b1;
        fetch(16'h1DA5, 1);
        run = 1'b0;
        exec(16'h3001);
        check("wrap_count", instr_count, 16'h0000);
        check("wrap_ip", ip, 16'h3001);
        repeat (3) tick();

        check("addr_q_empty", 16'(exp_addr.size()), 16'd0);
        check("ir_q_empty", 16'(exp_ir.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
